// File: rtl/elbeth_pipe_skid_register_if.sv
// Handshake bundle for the elbeth pipeline skid stage: upstream offer, downstream head, flush and fill level.
// The master side is the surrounding pipeline; the slave side is the stage itself.
interface elbeth_pipe_skid_register_if #(
    parameter int DATA_W = 64,
    parameter int EXC_W  = 4
);
    logic              up_valid;
    logic              up_ready;
    logic [DATA_W-1:0] up_data;
    logic              up_except;
    logic [EXC_W-1:0]  up_except_src;
    logic              ctrl_flush;
    logic              dn_valid;
    logic              dn_ready;
    logic [DATA_W-1:0] dn_data;
    logic              dn_except;
    logic [EXC_W-1:0]  dn_except_src;
    logic [1:0]        occupancy;

    modport master (
        output up_valid,
        output up_data,
        output up_except,
        output up_except_src,
        output ctrl_flush,
        output dn_ready,
        input  up_ready,
        input  dn_valid,
        input  dn_data,
        input  dn_except,
        input  dn_except_src,
        input  occupancy
    );

    modport slave (
        input  up_valid,
        input  up_data,
        input  up_except,
        input  up_except_src,
        input  ctrl_flush,
        input  dn_ready,
        output up_ready,
        output dn_valid,
        output dn_data,
        output dn_except,
        output dn_except_src,
        output occupancy
    );
endinterface

// File: rtl/elbeth_pipe_skid_register.sv
// Two-entry pipeline skid register: a main register feeding the downstream port plus one skid slot,
// so up_ready can be registered without losing throughput.
module elbeth_pipe_skid_register #(
    parameter int                 DATA_W = 64,
    parameter int                 EXC_W  = 4,
    parameter logic [DATA_W-1:0]  BUBBLE = {32'h00000013, 32'h0}
) (
    input  logic                           clk,
    input  logic                           rst,
    elbeth_pipe_skid_register_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              exc;
        logic [EXC_W-1:0]  src;
    } entry_t;

    localparam entry_t BUBBLE_ENTRY = '{data: BUBBLE, exc: 1'b0, src: '0};

    state_e     state_q, state_d;
    entry_t     main_q, main_d;
    entry_t     skid_q, skid_d;
    logic       up_ready_q, up_ready_d;
    logic       dn_valid_q, dn_valid_d;
    logic [1:0] occupancy_q, occupancy_d;

    entry_t     in_entry;
    logic       in_xfer;
    logic       out_xfer;

    assign in_entry = '{data: bus.up_data, exc: bus.up_except, src: bus.up_except_src};
    assign in_xfer  = bus.up_valid & up_ready_q;
    assign out_xfer = dn_valid_q & bus.dn_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (bus.ctrl_flush) begin
            // Flush wins over any transfer offered in the same cycle.
            state_d = ST_EMPTY;
            main_d  = BUBBLE_ENTRY;
            skid_d  = BUBBLE_ENTRY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d = ST_ONE;
                        main_d  = in_entry;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_entry;
                    end else if (in_xfer) begin
                        state_d = ST_FULL;
                        skid_d  = in_entry;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                        main_d  = BUBBLE_ENTRY;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE_ENTRY;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE_ENTRY;
                    skid_d  = BUBBLE_ENTRY;
                end
            endcase
        end
    end

    always_comb begin
        up_ready_d  = (state_d != ST_FULL);
        dn_valid_d  = (state_d != ST_EMPTY);
        occupancy_d = 2'd0;
        case (state_d)
            ST_ONE:  occupancy_d = 2'd1;
            ST_FULL: occupancy_d = 2'd2;
            default: occupancy_d = 2'd0;
        endcase
    end

    // up_ready stays low throughout reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= BUBBLE_ENTRY;
            skid_q      <= BUBBLE_ENTRY;
            up_ready_q  <= 1'b0;
            dn_valid_q  <= 1'b0;
            occupancy_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            up_ready_q  <= up_ready_d;
            dn_valid_q  <= dn_valid_d;
            occupancy_q <= occupancy_d;
        end
    end

    assign bus.up_ready      = up_ready_q;
    assign bus.dn_valid      = dn_valid_q;
    assign bus.dn_data       = main_q.data;
    assign bus.dn_except     = main_q.exc;
    assign bus.dn_except_src = main_q.src;
    assign bus.occupancy     = occupancy_q;

endmodule

// File: tb/tb_elbeth_pipe_skid_register.sv
// Bench for elbeth_pipe_skid_register: directed vector table, hand-written reset and streaming
// sequences, then randomized traffic against a queue-based reference model.
module tb_elbeth_pipe_skid_register;

    localparam int          DW  = 64;
    localparam int          EW  = 4;
    localparam logic [63:0] BUB = 64'h00000013_00000000;
    localparam logic [63:0] VA  = 64'h00A00093_00000004;
    localparam logic [63:0] VB  = 64'h00B00113_00000008;
    localparam logic [63:0] VC  = 64'h00C00193_0000000C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    elbeth_pipe_skid_register_if #(.DATA_W(DW), .EXC_W(EW)) bus ();

    elbeth_pipe_skid_register #(.DATA_W(DW), .EXC_W(EW), .BUBBLE(BUB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        flush;
        logic        uv;
        logic        dr;
        logic [63:0] data;
        logic        exc;
        logic [3:0]  src;
        logic        e_dv;
        logic [63:0] e_data;
        logic        e_exc;
        logic [3:0]  e_src;
        logic [1:0]  e_occ;
        logic        e_rdy;
    } vec_t;

    typedef struct {
        logic [63:0] d;
        logic        e;
        logic [3:0]  s;
    } ent_t;

    vec_t vecs[21];
    ent_t mq[$];
    ent_t nent;
    logic m_rdy;
    logic r_flush, r_uv, r_dr, take, give;
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic drive(input logic flush, input logic uv, input logic dr,
                         input logic [63:0] data, input logic exc, input logic [3:0] src);
        bus.ctrl_flush    = flush;
        bus.up_valid      = uv;
        bus.dn_ready      = dr;
        bus.up_data       = data;
        bus.up_except     = exc;
        bus.up_except_src = src;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic e_dv, input logic [63:0] e_data,
                         input logic e_exc, input logic [3:0] e_src, input logic [1:0] e_occ,
                         input logic e_rdy);
        vectors++;
        if (bus.dn_valid !== e_dv || bus.dn_data !== e_data || bus.dn_except !== e_exc ||
            bus.dn_except_src !== e_src || bus.occupancy !== e_occ || bus.up_ready !== e_rdy) begin
            miscompares++;
            $display("FAIL %s: got dv=%0b data=%h exc=%0b src=%h occ=%0d rdy=%0b, expected dv=%0b data=%h exc=%0b src=%h occ=%0d rdy=%0b",
                     name, bus.dn_valid, bus.dn_data, bus.dn_except, bus.dn_except_src,
                     bus.occupancy, bus.up_ready, e_dv, e_data, e_exc, e_src, e_occ, e_rdy);
        end else begin
            $display("ok   %s: dv=%0b data=%h exc=%0b src=%h occ=%0d rdy=%0b",
                     name, bus.dn_valid, bus.dn_data, bus.dn_except, bus.dn_except_src,
                     bus.occupancy, bus.up_ready);
        end
    endtask

    initial begin
        // flush uv dr data exc src | dv data exc src occ rdy
        vecs[0]  = '{1'b0, 1'b1, 1'b1, VA,  1'b0, 4'h0, 1'b1, VA,  1'b0, 4'h0, 2'd1, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, VC,  1'b0, 4'h0, 1'b0, BUB, 1'b0, 4'h0, 2'd0, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, VA,  1'b0, 4'h0, 1'b1, VA,  1'b0, 4'h0, 2'd1, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, VB,  1'b0, 4'h0, 1'b1, VA,  1'b0, 4'h0, 2'd2, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, VC,  1'b0, 4'h0, 1'b1, VA,  1'b0, 4'h0, 2'd2, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, VC,  1'b0, 4'h0, 1'b1, VB,  1'b0, 4'h0, 2'd1, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, VC,  1'b0, 4'h0, 1'b0, BUB, 1'b0, 4'h0, 2'd0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, VB,  1'b0, 4'h0, 1'b1, VB,  1'b0, 4'h0, 2'd1, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, VA,  1'b1, 4'h3, 1'b1, VB,  1'b0, 4'h0, 2'd2, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, VC,  1'b0, 4'h0, 1'b1, VA,  1'b1, 4'h3, 2'd1, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, VC,  1'b0, 4'h0, 1'b0, BUB, 1'b0, 4'h0, 2'd0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, VA,  1'b0, 4'h0, 1'b1, VA,  1'b0, 4'h0, 2'd1, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b0, VB,  1'b0, 4'h0, 1'b1, VA,  1'b0, 4'h0, 2'd2, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b1, VC,  1'b1, 4'h5, 1'b0, BUB, 1'b0, 4'h0, 2'd0, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b1, VC,  1'b0, 4'h0, 1'b0, BUB, 1'b0, 4'h0, 2'd0, 1'b1};
        vecs[15] = '{1'b1, 1'b1, 1'b1, VC,  1'b0, 4'h0, 1'b0, BUB, 1'b0, 4'h0, 2'd0, 1'b1};
        vecs[16] = '{1'b0, 1'b1, 1'b1, VA,  1'b0, 4'h0, 1'b1, VA,  1'b0, 4'h0, 2'd1, 1'b1};
        vecs[17] = '{1'b0, 1'b1, 1'b1, VB,  1'b0, 4'h0, 1'b1, VB,  1'b0, 4'h0, 2'd1, 1'b1};
        vecs[18] = '{1'b0, 1'b0, 1'b1, VC,  1'b0, 4'h0, 1'b0, BUB, 1'b0, 4'h0, 2'd0, 1'b1};
        vecs[19] = '{1'b0, 1'b1, 1'b0, VA,  1'b0, 4'h0, 1'b1, VA,  1'b0, 4'h0, 2'd1, 1'b1};
        vecs[20] = '{1'b1, 1'b0, 1'b0, VC,  1'b0, 4'h0, 1'b0, BUB, 1'b0, 4'h0, 2'd0, 1'b1};

        drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 4'h0);
        #2 rst = 1'b0;
        #1 check("reset_async", 1'b0, BUB, 1'b0, 4'h0, 2'd0, 1'b0);
        cycle();
        rst = 1'b1;
        cycle();
        check("reset_release", 1'b0, BUB, 1'b0, 4'h0, 2'd0, 1'b1);

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].flush, vecs[i].uv, vecs[i].dr, vecs[i].data, vecs[i].exc, vecs[i].src);
            cycle();
            check($sformatf("vec%0d", i), vecs[i].e_dv, vecs[i].e_data, vecs[i].e_exc,
                  vecs[i].e_src, vecs[i].e_occ, vecs[i].e_rdy);
        end

        // Asynchronous reset dropped between edges while holding one entry.
        drive(1'b0, 1'b1, 1'b0, VB, 1'b1, 4'h7);
        cycle();
        check("pre_reset_one", 1'b1, VB, 1'b1, 4'h7, 2'd1, 1'b1);
        #2 rst = 1'b0;
        #1 check("midcycle_reset", 1'b0, BUB, 1'b0, 4'h0, 2'd0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, VA, 1'b0, 4'h0);
        cycle();
        check("held_in_reset", 1'b0, BUB, 1'b0, 4'h0, 2'd0, 1'b0);
        rst = 1'b1;
        cycle();
        check("first_edge_after_reset", 1'b0, BUB, 1'b0, 4'h0, 2'd0, 1'b1);
        cycle();
        check("first_accept_after_reset", 1'b1, VA, 1'b0, 4'h0, 2'd1, 1'b1);

        // Back-to-back stream with downstream always ready.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b1, {32'h00100013 + 32'(i), 32'(4 * i)}, 1'b0, 4'h0);
            cycle();
            check($sformatf("stream%0d", i), 1'b1, {32'h00100013 + 32'(i), 32'(4 * i)},
                  1'b0, 4'h0, 2'd1, 1'b1);
        end
        drive(1'b0, 1'b0, 1'b1, '0, 1'b0, 4'h0);
        cycle();
        check("stream_drain", 1'b0, BUB, 1'b0, 4'h0, 2'd0, 1'b1);

        // Randomized traffic against a two-slot FIFO model with a registered ready.
        mq.delete();
        m_rdy = 1'b1;
        for (int i = 0; i < 600; i++) begin
            r_flush = ($urandom_range(0, 24) == 0);
            r_uv    = $urandom_range(0, 1) == 1;
            r_dr    = $urandom_range(0, 2) != 0;
            nent.d  = {$urandom, $urandom};
            nent.e  = $urandom_range(0, 3) == 0;
            nent.s  = 4'($urandom_range(0, 15));
            drive(r_flush, r_uv, r_dr, nent.d, nent.e, nent.s);
            if (r_flush) begin
                mq.delete();
                m_rdy = 1'b1;
            end else begin
                take = r_uv && m_rdy;
                give = (mq.size() > 0) && r_dr;
                if (give) void'(mq.pop_front());
                if (take) mq.push_back(nent);
                m_rdy = (mq.size() < 2);
            end
            cycle();
            if (mq.size() > 0)
                check($sformatf("rand%0d", i), 1'b1, mq[0].d, mq[0].e, mq[0].s,
                      2'(mq.size()), m_rdy);
            else
                check($sformatf("rand%0d", i), 1'b0, BUB, 1'b0, 4'h0, 2'd0, m_rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
